// File: rtl/iob_soc_opencryptolinux_iob_arbiter_pkg.sv
// Shared types and width helpers for the IOb round-robin arbiter.
//   arb_state_t : grant state (FREE = combinational search, LOCKED = hold grant)
//   id_width    : bits needed to name a master, never below 1
//   ptr_width   : bits needed to index the outstanding-read queue
package iob_soc_opencryptolinux_iob_arbiter_pkg;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n_masters);
        return (n_masters <= 2) ? 1 : $clog2(n_masters);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/iob_soc_opencryptolinux_arb_id_fifo.sv
// Register-based synchronous FIFO holding the master IDs of outstanding reads.
//   clk_i/cke_i/arst_i : clock, clock enable, async active-high reset
//   push_i/din_i       : enqueue an ID (ignored when full)
//   pop_i              : dequeue the head (ignored when empty)
//   head_o             : oldest queued ID
//   full_o/empty_o     : occupancy flags
import iob_soc_opencryptolinux_iob_arbiter_pkg::*;

module iob_soc_opencryptolinux_arb_id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         arst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [PTR_W:0]          cnt_q;
    logic                    do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (cke_i) begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/iob_soc_opencryptolinux_iob_arbiter.sv
// Round-robin arbiter sharing one IOb slave port among N_MASTERS IOb masters.
// Outstanding read IDs are queued in order so each rvalid returns to its issuer.
//   clk_i/cke_i/arst_i       : clock, clock enable, async active-high reset
//   m_avalid_i/m_addr_i/...  : packed master request buses (master k at slice k)
//   m_ready_o                : per-master accept, one-hot or zero
//   m_rvalid_o/m_rdata_o     : per-master read valid, broadcast read data
//   s_*                      : slave request/response port
//   err_o                    : sticky, response seen with no read outstanding
import iob_soc_opencryptolinux_iob_arbiter_pkg::*;

module iob_soc_opencryptolinux_iob_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUT   = 4
) (
    input  logic                            clk_i,
    input  logic                            cke_i,
    input  logic                            arst_i,
    input  logic [N_MASTERS-1:0]            m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i,
    output logic [N_MASTERS-1:0]            m_ready_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic                            s_avalid_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    output logic [DATA_W/8-1:0]             s_wstrb_o,
    input  logic                            s_ready_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_W-1:0]               s_rdata_i,
    output logic                            err_o
);
    localparam int ID_W   = id_width(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] lock_q, lock_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic            err_q, err_d;

    logic [ID_W-1:0] rr_gnt, gnt, head;
    logic            rr_vld, gnt_req, is_rd, blocked, accept;
    logic            fifo_full, fifo_empty, push, pop;

    // First requester at or above rr_q, wrapping modulo N_MASTERS.
    always_comb begin
        logic [ID_W:0] idx;
        rr_vld = 1'b0;
        rr_gnt = rr_q;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = (ID_W+1)'(rr_q) + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_MASTERS)) idx = idx - (ID_W+1)'(N_MASTERS);
            if (!rr_vld && m_avalid_i[idx[ID_W-1:0]]) begin
                rr_vld = 1'b1;
                rr_gnt = idx[ID_W-1:0];
            end
        end
    end

    assign gnt     = (state_q == ARB_LOCKED) ? lock_q : rr_gnt;
    assign gnt_req = (state_q == ARB_LOCKED) ? m_avalid_i[lock_q] : rr_vld;

    assign s_addr_o  = m_addr_i[gnt*ADDR_W +: ADDR_W];
    assign s_wdata_o = m_wdata_i[gnt*DATA_W +: DATA_W];
    assign s_wstrb_o = m_wstrb_i[gnt*STRB_W +: STRB_W];

    // Blocking uses only the registered full flag, so a same-cycle response
    // never reaches s_avalid_o combinationally.
    assign is_rd      = ~|s_wstrb_o;
    assign blocked    = is_rd && fifo_full;
    assign s_avalid_o = gnt_req && !blocked;
    assign accept     = s_avalid_o && s_ready_i;

    assign push      = accept && is_rd;
    assign pop       = s_rvalid_i && !fifo_empty;
    assign m_rdata_o = s_rdata_i;
    assign err_o     = err_q;

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            m_ready_o[k]  = accept && (gnt == ID_W'(k));
            m_rvalid_o[k] = pop && (head == ID_W'(k));
        end
    end

    // Any presented-but-unaccepted request (slave stall or queue-full block)
    // pins the grant; a master that drops avalid releases the lock.
    always_comb begin
        state_d = ARB_FREE;
        lock_d  = lock_q;
        rr_d    = rr_q;
        err_d   = err_q | (s_rvalid_i && fifo_empty);
        if (gnt_req && !accept) begin
            state_d = ARB_LOCKED;
            lock_d  = gnt;
        end
        if (accept) rr_d = (gnt == ID_W'(N_MASTERS-1)) ? '0 : gnt + 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ARB_FREE;
            lock_q  <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    iob_soc_opencryptolinux_arb_id_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_i  (arst_i),
        .push_i  (push),
        .din_i   (gnt),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_iob_soc_opencryptolinux_iob_arbiter.sv
// Directed bench for the IOb arbiter with a response scoreboard: the issuing
// master of every read the bench expects accepted is queued, and each slave
// response is checked against the queue head.
module tb_iob_soc_opencryptolinux_iob_arbiter;
    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        arst = 1'b1;
    logic [1:0]  m_avalid = '0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_wstrb = '0;
    logic [1:0]  m_ready, m_rvalid;
    logic [31:0] m_rdata;
    logic        s_avalid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic        s_rvalid = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        err;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    iob_soc_opencryptolinux_iob_arbiter #(
        .N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4)
    ) dut (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_wstrb_i(m_wstrb), .m_ready_o(m_ready), .m_rvalid_o(m_rvalid),
        .m_rdata_o(m_rdata), .s_avalid_o(s_avalid), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_ready_i(s_ready),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .err_o(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setm(input int k, input logic av, input logic [31:0] a, input logic [3:0] st);
        m_avalid[k]          = av;
        m_addr[k*32 +: 32]   = a;
        m_wdata[k*32 +: 32]  = a ^ 32'h5a5a_0000;
        m_wstrb[k*4 +: 4]    = st;
    endtask

    // Drive a response this cycle and check routing against the scoreboard.
    task automatic resp_on(input logic [31:0] d);
        int id;
        s_rvalid = 1'b1;
        s_rdata  = d;
        #1;
        if (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            chk("rvalid_route", m_rvalid, 64'(2'b01 << id));
            chk("rdata", m_rdata, d);
        end else begin
            chk("rvalid_spurious", m_rvalid, 0);
        end
    endtask

    task automatic resp(input logic [31:0] d);
        resp_on(d);
        cyc();
        s_rvalid = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_ready", m_ready, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_savalid", s_avalid, 0);
        chk("rst_err", err, 0);
        cyc(); cyc();
        arst = 1'b0;
        cyc();

        // two simultaneous reads, rr_ptr = 0
        s_ready = 1'b1;
        setm(0, 1, 32'h10, 4'h0);
        setm(1, 1, 32'h20, 4'h0);
        #1;
        chk("t1_savalid", s_avalid, 1);
        chk("t1_addr0", s_addr, 32'h10);
        chk("t1_ready0", m_ready, 2'b01);
        exp_q.push_back(0);
        cyc();
        setm(0, 0, 0, 0);
        #1;
        chk("t1_addr1", s_addr, 32'h20);
        chk("t1_ready1", m_ready, 2'b10);
        exp_q.push_back(1);
        cyc();
        setm(1, 0, 0, 0);
        resp(32'hAAAA);
        resp(32'hBBBB);

        // slave stall on master 0 write, master 1 joins
        s_ready = 1'b0;
        setm(0, 1, 32'h30, 4'hF);
        #1;
        chk("t2_savalid", s_avalid, 1);
        chk("t2_stall_ready", m_ready, 0);
        cyc();
        setm(1, 1, 32'h40, 4'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t2_hold_addr", s_addr, 32'h30);
            chk("t2_hold_ready", m_ready, 0);
            cyc();
        end
        s_ready = 1'b1;
        #1;
        chk("t2_acc0", m_ready, 2'b01);
        chk("t2_wdata", s_wdata, 32'h5a5a_0030);
        chk("t2_wstrb", s_wstrb, 4'hF);
        cyc();
        setm(0, 0, 0, 0);
        #1;
        chk("t2_addr1", s_addr, 32'h40);
        chk("t2_acc1", m_ready, 2'b10);
        exp_q.push_back(1);
        cyc();
        setm(1, 0, 0, 0);
        resp(32'h1111);

        // fill the queue with four reads from master 0
        for (int i = 0; i < 4; i++) begin
            setm(0, 1, 32'h100 + 32'(i), 4'h0);
            #1;
            chk("t3_fill", m_ready, 2'b01);
            exp_q.push_back(0);
            cyc();
        end
        setm(0, 1, 32'h104, 4'h0);
        #1;
        chk("t3_full_savalid", s_avalid, 0);
        chk("t3_full_ready", m_ready, 0);
        cyc();
        setm(1, 1, 32'h200, 4'h3);
        #1;
        chk("t3_wr_behind_lock", m_ready, 0);
        resp_on(32'hC0);
        chk("t3_no_combine", s_avalid, 0);
        cyc();
        s_rvalid = 1'b0;
        #1;
        chk("t3_unblock_ready", m_ready, 2'b01);
        chk("t3_unblock_addr", s_addr, 32'h104);
        exp_q.push_back(0);
        cyc();
        setm(0, 0, 0, 0);
        #1;
        chk("t3_wr_at_full", m_ready, 2'b10);
        cyc();
        setm(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) resp(32'hD0 + 32'(i));

        // push and pop together at count 2
        setm(0, 1, 32'h300, 4'h0);
        #1;
        chk("t4_rd0", m_ready, 2'b01);
        exp_q.push_back(0);
        cyc();
        setm(0, 0, 0, 0);
        setm(1, 1, 32'h304, 4'h0);
        #1;
        chk("t4_rd1", m_ready, 2'b10);
        exp_q.push_back(1);
        cyc();
        setm(1, 0, 0, 0);
        setm(0, 1, 32'h308, 4'h0);
        resp_on(32'hE0);
        chk("t4_pushpop_ready", m_ready, 2'b01);
        exp_q.push_back(0);
        cyc();
        s_rvalid = 1'b0;
        setm(0, 0, 0, 0);
        resp(32'hE1);
        resp(32'hE2);

        // response with empty queue
        resp(32'hF0);
        chk("t5_err_set", err, 1);
        cyc(); cyc();
        chk("t5_err_held", err, 1);

        // reset with two reads outstanding
        setm(1, 1, 32'h400, 4'h0);
        #1;
        chk("t6_rd1", m_ready, 2'b10);
        exp_q.push_back(1);
        cyc();
        setm(1, 0, 0, 0);
        setm(0, 1, 32'h404, 4'h0);
        #1;
        chk("t6_rd0", m_ready, 2'b01);
        exp_q.push_back(0);
        cyc();
        setm(0, 0, 0, 0);
        arst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_ready", m_ready, 0);
        chk("t6_rst_rvalid", m_rvalid, 0);
        chk("t6_rst_savalid", s_avalid, 0);
        chk("t6_rst_err", err, 0);
        cyc();
        arst = 1'b0;
        cyc();
        setm(0, 1, 32'h500, 4'h0);
        setm(1, 1, 32'h504, 4'h0);
        #1;
        chk("t6_first_gnt", m_ready, 2'b01);
        exp_q.push_back(0);
        cyc();
        setm(0, 0, 0, 0);
        #1;
        chk("t6_second_gnt", m_ready, 2'b10);
        exp_q.push_back(1);
        cyc();
        setm(1, 0, 0, 0);
        resp(32'h600);
        resp(32'h601);
        chk("t6_err_clear", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
